ps2_event_fifo_decoder: RTL and testbench

//  Turns raw PS/2 scancode bytes from the receiver (rx_data + rx_done_tick) into
//  key events {ext, brk, code} and queues them in a first-word-fall-through FIFO.

---
 rtl/ps2_event_fifo_decoder_pkg.sv | 43 ++++
 rtl/ps2_event_fifo_decoder_digit_lut.sv | 26 ++
 rtl/ps2_event_fifo_decoder.sv | 152 +++++++++++++++
 tb/tb_ps2_event_fifo_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_event_fifo_decoder_pkg.sv
// Shared PS/2 constants, event types and helpers for the scancode event decoder.
package ps2_event_fifo_decoder_pkg;

  localparam logic [7:0] PS2_E0     = 8'hE0;
  localparam logic [7:0] PS2_F0     = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR_LO = 8'h00;
  localparam logic [7:0] PS2_ERR_HI = 8'hFF;

  localparam int PS2_REF_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } prefix_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  typedef struct packed {
    logic       valid;
    logic       ext;
    logic [7:0] code;
  } last_make_t;

  function automatic logic is_ctrl_response(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_E0) || (b == PS2_F0);
  endfunction

endpackage

// File: rtl/ps2_event_fifo_decoder_digit_lut.sv
// Combinational map from set-2 scancodes of the main-row digit keys to their value 0..9.
module ps2_digit_lut (
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] value
);

  always_comb begin
    hit   = 1'b1;
    value = '0;
    case (code)
      8'h45:   value = 4'd0;
      8'h16:   value = 4'd1;
      8'h1E:   value = 4'd2;
      8'h26:   value = 4'd3;
      8'h25:   value = 4'd4;
      8'h2E:   value = 4'd5;
      8'h36:   value = 4'd6;
      8'h3D:   value = 4'd7;
      8'h3E:   value = 4'd8;
      8'h46:   value = 4'd9;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_event_fifo_decoder.sv
// Decodes PS/2 scancode bytes into {ext, brk, code} key events, queues them in a
// first-word-fall-through FIFO and tracks the value of the last released digit key.
module ps2_event_fifo_decoder
  import ps2_event_fifo_decoder_pkg::*;
#(
  parameter int N           = PS2_REF_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int REPORT_MAKE = 1,
  parameter int FILTER_REP  = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done_tick,
  input  logic         rd_en,
  input  logic         clr_ovf,
  output logic         ev_valid,
  output logic [7:0]   ev_code,
  output logic         ev_ext,
  output logic         ev_brk,
  output logic         fifo_full,
  output logic         overflow,
  output logic [N-1:0] ref_value
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  prefix_state_e state_q, state_d;
  last_make_t    last_make_q, last_make_d;
  logic [N-1:0]  ref_q, ref_d;

  ps2_event_t    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          digit_hit;
  logic [3:0]    digit_val;
  logic          is_make, is_brk, ext_in, push;
  ps2_event_t    ev_in;
  logic          pop, full, wr_en, drop;

  ps2_digit_lut u_digit_lut (
    .code  (rx_data),
    .hit   (digit_hit),
    .value (digit_val)
  );

  always_comb begin
    state_d     = state_q;
    last_make_d = last_make_q;
    ref_d       = ref_q;
    is_make     = 1'b0;
    is_brk      = 1'b0;
    ext_in      = 1'b0;
    push        = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == PS2_E0)              state_d = ST_EXT;
          else if (rx_data == PS2_F0)         state_d = ST_BRK;
          else if (!is_ctrl_response(rx_data)) is_make = 1'b1;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (rx_data == PS2_F0)      state_d = ST_EXTBRK;
          else if (rx_data == PS2_E0) state_d = ST_EXT;
          else begin
            is_make = 1'b1;
            ext_in  = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          is_brk  = !is_prefix(rx_data);
        end
        ST_EXTBRK: begin
          state_d = ST_IDLE;
          is_brk  = !is_prefix(rx_data);
          ext_in  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // last_make tracks every make, even ones that are filtered or not reported
    if (is_make) begin
      last_make_d = '{valid: 1'b1, ext: ext_in, code: rx_data};
      push = (REPORT_MAKE != 0) &&
             !((FILTER_REP != 0) && last_make_q.valid &&
               (last_make_q.ext == ext_in) && (last_make_q.code == rx_data));
    end
    if (is_brk) begin
      last_make_d = '0;
      push        = 1'b1;
      if (!ext_in && digit_hit) ref_d = N'(digit_val);
    end
    ev_in = '{ext: ext_in, brk: is_brk, code: rx_data};
  end

  // A push while full is still accepted when the head is popped on the same edge
  always_comb begin
    pop        = rd_en && (count_q != '0);
    full       = (count_q == CW'(FIFO_DEPTH));
    wr_en      = push && (!full || pop);
    drop       = push && full && !pop;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_make_q <= '0;
      ref_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_make_q <= last_make_d;
      ref_q       <= ref_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_ptr_q] <= ev_in;
  end

  // Storage is not reset, so the head fields are forced to zero while empty
  always_comb begin
    ev_valid  = (count_q != '0);
    ev_code   = ev_valid ? mem_q[rd_ptr_q].code : '0;
    ev_ext    = ev_valid ? mem_q[rd_ptr_q].ext  : 1'b0;
    ev_brk    = ev_valid ? mem_q[rd_ptr_q].brk  : 1'b0;
    fifo_full = full;
    overflow  = overflow_q;
    ref_value = ref_q;
  end

endmodule

// File: tb/tb_ps2_event_fifo_decoder.sv
// Directed self-checking bench: default build plus no-filter and break-only variants.
module tb_ps2_event_fifo_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done_tick = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;

  logic       a_valid, a_ext, a_brk, a_full, a_ovf;
  logic [7:0] a_code;
  logic [3:0] a_ref;
  logic       b_valid, b_ext, b_brk, b_full, b_ovf;
  logic [7:0] b_code;
  logic [3:0] b_ref;
  logic       c_valid, c_ext, c_brk, c_full, c_ovf;
  logic [7:0] c_code;
  logic [3:0] c_ref;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_event_fifo_decoder #(.N(4), .FIFO_DEPTH(4), .REPORT_MAKE(1), .FILTER_REP(1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(a_valid), .ev_code(a_code),
    .ev_ext(a_ext), .ev_brk(a_brk), .fifo_full(a_full), .overflow(a_ovf), .ref_value(a_ref));

  ps2_event_fifo_decoder #(.N(4), .FIFO_DEPTH(4), .REPORT_MAKE(1), .FILTER_REP(0)) dut_nofilt (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(b_valid), .ev_code(b_code),
    .ev_ext(b_ext), .ev_brk(b_brk), .fifo_full(b_full), .overflow(b_ovf), .ref_value(b_ref));

  ps2_event_fifo_decoder #(.N(4), .FIFO_DEPTH(4), .REPORT_MAKE(0), .FILTER_REP(1)) dut_brkonly (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .ev_valid(c_valid), .ev_code(c_code),
    .ev_ext(c_ext), .ev_brk(c_brk), .fifo_full(c_full), .overflow(c_ovf), .ref_value(c_ref));

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Head of the default instance as {valid, ext, brk, code}
  function automatic logic [10:0] head_a();
    return {a_valid, a_ext, a_brk, a_code};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_valid, a_code, a_ext, a_brk, a_full, a_ovf, a_ref} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {a_valid, a_code, a_ext, a_brk, a_full, a_ovf, a_ref});
    end
  endtask

  task automatic test_make_break();
    send_byte(8'h16);
    checks++;
    if (head_a() !== {3'b100, 8'h16}) begin failures++; $display("FAIL make16_head got=%h exp=%h", head_a(), {3'b100, 8'h16}); end
    checks++;
    if (a_ref !== 4'd0) begin failures++; $display("FAIL make16_ref got=%0d exp=0", a_ref); end
    send_byte(8'hF0);
    send_byte(8'h16);
    checks++;
    if (a_ref !== 4'd1) begin failures++; $display("FAIL break16_ref got=%0d exp=1", a_ref); end
    pop_one();
    checks++;
    if (head_a() !== {3'b101, 8'h16}) begin failures++; $display("FAIL break16_head got=%h exp=%h", head_a(), {3'b101, 8'h16}); end
    pop_one();
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL make_break_empty got=%b exp=0", a_valid); end
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    checks++;
    if (head_a() !== {3'b110, 8'h75}) begin failures++; $display("FAIL ext_make_head got=%h exp=%h", head_a(), {3'b110, 8'h75}); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h45);
    checks++;
    if (a_ref !== 4'd1) begin failures++; $display("FAIL ext_ref_unchanged got=%0d exp=1", a_ref); end
    pop_one();
    checks++;
    if (head_a() !== {3'b111, 8'h75}) begin failures++; $display("FAIL ext_break_head got=%h exp=%h", head_a(), {3'b111, 8'h75}); end
    pop_one();
    checks++;
    if (head_a() !== {3'b111, 8'h45}) begin failures++; $display("FAIL ext_break45_head got=%h exp=%h", head_a(), {3'b111, 8'h45}); end
    pop_one();
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL ext_empty got=%b exp=0", a_valid); end
  endtask

  task automatic test_repeat_filter();
    do_reset();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    checks++;
    if ({a_full, b_full, b_ovf} !== 3'b010) begin failures++; $display("FAIL rep_full_flags got=%b exp=010", {a_full, b_full, b_ovf}); end
    checks++;
    if (head_a() !== {3'b100, 8'h1C}) begin failures++; $display("FAIL rep_head0 got=%h exp=%h", head_a(), {3'b100, 8'h1C}); end
    pop_one();
    checks++;
    if (head_a() !== {3'b101, 8'h1C}) begin failures++; $display("FAIL rep_head1 got=%h exp=%h", head_a(), {3'b101, 8'h1C}); end
    pop_one();
    checks++;
    if ({a_valid, b_valid, b_brk, b_code} !== {3'b010, 8'h1C}) begin
      failures++; $display("FAIL rep_after2 got=%h exp=%h", {a_valid, b_valid, b_brk, b_code}, {3'b010, 8'h1C});
    end
    pop_one();
    checks++;
    if ({b_valid, b_brk, b_code} !== {2'b11, 8'h1C}) begin failures++; $display("FAIL rep_nofilt_break got=%h exp=%h", {b_valid, b_brk, b_code}, {2'b11, 8'h1C}); end
    pop_one();
    checks++;
    if (b_valid !== 1'b0) begin failures++; $display("FAIL rep_nofilt_empty got=%b exp=0", b_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [7:0] rest [3] = '{8'h24, 8'h2D, 8'h35};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(keys[i]);
    checks++;
    if ({a_full, a_ovf, a_code} !== {2'b11, 8'h15}) begin failures++; $display("FAIL ovf_state got=%h exp=%h", {a_full, a_ovf, a_code}, {2'b11, 8'h15}); end
    @(negedge clk);
    rx_data = 8'h35; rx_done_tick = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; rd_en = 1'b0;
    checks++;
    if ({a_full, a_ovf, a_code} !== {2'b11, 8'h1D}) begin failures++; $display("FAIL push_pop_full got=%h exp=%h", {a_full, a_ovf, a_code}, {2'b11, 8'h1D}); end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++;
    if ({a_full, a_ovf} !== 2'b10) begin failures++; $display("FAIL clr_ovf got=%b exp=10", {a_full, a_ovf}); end
    @(negedge clk);
    rx_data = 8'h3C; rx_done_tick = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (a_ovf !== 1'b1) begin failures++; $display("FAIL drop_beats_clr got=%b exp=1", a_ovf); end
    for (int i = 0; i < 3; i++) begin
      pop_one();
      checks++;
      if (head_a() !== {3'b100, rest[i]}) begin failures++; $display("FAIL wrap_head%0d got=%h exp=%h", i, head_a(), {3'b100, rest[i]}); end
    end
    pop_one();
    checks++;
    if ({a_valid, a_full} !== 2'b00) begin failures++; $display("FAIL wrap_empty got=%b exp=00", {a_valid, a_full}); end
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    send_byte(8'hE0);
    do_reset();
    send_byte(8'h45);
    checks++;
    if (head_a() !== {3'b100, 8'h45}) begin failures++; $display("FAIL reset_mid_prefix got=%h exp=%h", head_a(), {3'b100, 8'h45}); end
    pop_one();
    send_byte(8'hF0); send_byte(8'hF0);
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL f0f0_no_event got=%b exp=0", a_valid); end
    send_byte(8'h45);
    checks++;
    if (a_valid !== 1'b0) begin failures++; $display("FAIL repeat_45_filtered got=%b exp=0", a_valid); end
    send_byte(8'h16);
    checks++;
    if (head_a() !== {3'b100, 8'h16}) begin failures++; $display("FAIL idle_after_f0f0 got=%h exp=%h", head_a(), {3'b100, 8'h16}); end
  endtask

  task automatic test_break_only();
    do_reset();
    send_byte(8'hAA);
    checks++;
    if ({a_valid, c_valid} !== 2'b00) begin failures++; $display("FAIL self_test_no_event got=%b exp=00", {a_valid, c_valid}); end
    send_byte(8'h1E);
    checks++;
    if ({a_valid, c_valid} !== 2'b10) begin failures++; $display("FAIL brkonly_make_dropped got=%b exp=10", {a_valid, c_valid}); end
    send_byte(8'hF0); send_byte(8'h16);
    checks++;
    if ({c_valid, c_ext, c_brk, c_code, c_ref} !== {3'b101, 8'h16, 4'd1}) begin
      failures++; $display("FAIL brkonly_break16 got=%h exp=%h", {c_valid, c_ext, c_brk, c_code, c_ref}, {3'b101, 8'h16, 4'd1});
    end
    pop_one();
    send_byte(8'hF0); send_byte(8'h45);
    checks++;
    if ({c_valid, c_ext, c_brk, c_code, c_ref} !== {3'b101, 8'h45, 4'd0}) begin
      failures++; $display("FAIL brkonly_break45 got=%h exp=%h", {c_valid, c_ext, c_brk, c_code, c_ref}, {3'b101, 8'h45, 4'd0});
    end
    pop_one();
    checks++;
    if (c_valid !== 1'b0) begin failures++; $display("FAIL brkonly_empty got=%b exp=0", c_valid); end
  endtask

  task automatic test_digit_table();
    logic [7:0] codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    logic [3:0] vals  [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hF0); send_byte(codes[i]);
      checks++;
      if (a_ref !== vals[i]) begin failures++; $display("FAIL digit_%h got=%0d exp=%0d", codes[i], a_ref, vals[i]); end
    end
    send_byte(8'hF0); send_byte(8'h1C);
    checks++;
    if ({a_ref, a_ovf} !== {4'd0, 1'b1}) begin failures++; $display("FAIL nondigit_ref got=%h exp=01", {a_ref, a_ovf}); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat_filter();
    test_overflow();
    test_reset_mid_prefix();
    test_break_only();
    test_digit_table();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
